// File: rtl/cnn_pkg.sv
// Shared constants, loader state type and border helper for the LeNet image front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cnn_pkg;
  localparam int DATA_WIDTH   = 16;
  localparam int IMG_W        = 32;
  localparam int IMG_H        = 32;
  localparam int IN_W         = 28;
  localparam int PAD          = (IMG_W - IN_W) / 2;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int FRAME_BITS   = FRAME_PIXELS * DATA_WIDTH;
  localparam int IDX_W        = $clog2(FRAME_PIXELS);
  localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } loader_state_e;

  // True for stored-frame positions that lie in the zero border around the padded input.
  function automatic logic is_border(input int idx);
    int r;
    int c;
    r = idx / IMG_W;
    c = idx % IMG_W;
    return (r < PAD) || (r >= PAD + IN_W) || (c < PAD) || (c >= PAD + IN_W);
  endfunction
endpackage

// File: rtl/cnn_image_loader_if.sv
// Pixel stream in and flattened frame bus out of the image loader.
// Latency: n/a (wiring only).
// Backpressure: s_ready throttles the pixel stream; frame_ack releases the held frame.
interface cnn_image_loader_if;
  import cnn_pkg::*;

  logic [DATA_WIDTH-1:0] s_pixel;
  logic                  s_valid;
  logic                  s_sof;
  logic                  s_ready;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_ack;

  // Source of pixels and consumer of the frame.
  modport master (
    output s_pixel, s_valid, s_sof, frame_ack,
    input  s_ready, frame_data, frame_valid
  );

  // The loader itself.
  modport slave (
    input  s_pixel, s_valid, s_sof, frame_ack,
    output s_ready, frame_data, frame_valid
  );
endinterface

// File: rtl/cnn_loader_addr_gen.sv
// Row/column tracker turning stored beats into frame write indices; CNN_LOADER_PAD_EN adds the border offset.
// Latency: index and last flag are combinational for the current beat; counters advance on the beat edge.
// Backpressure: none of its own; advances only on beats the loader stores.
module cnn_loader_addr_gen
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             beat,
  input  logic             sof,
  output logic [IDX_W-1:0] wr_idx,
  output logic             last
);
`ifdef CNN_LOADER_PAD_EN
  localparam int ROWS = IN_W;
  localparam int COLS = IN_W;
  localparam int OFF  = PAD;
`else
  localparam int ROWS = IMG_H;
  localparam int COLS = IMG_W;
  localparam int OFF  = 0;
`endif
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [RW-1:0] eff_row;
  logic [CW-1:0] eff_col;
  logic [31:0]   idx_full;

  // An SOF beat always lands on the first input position, whatever the counters hold.
  always_comb begin
    eff_row  = sof ? '0 : row;
    eff_col  = sof ? '0 : col;
    idx_full = (32'(eff_row) + OFF) * IMG_W + 32'(eff_col) + OFF;
    wr_idx   = idx_full[IDX_W-1:0];
    last     = !sof && (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));
  end

  // Counters point at the position of the next beat; SOF restarts them just past the origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (beat) begin
      if (sof) begin
        row <= '0;
        col <= CW'(1);
      end else if (col == CW'(COLS - 1)) begin
        col <= '0;
        row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cnn_image_loader.sv
// Assembles a raster pixel stream into a held 32x32 frame for the conv stage (pad mode: CNN_LOADER_PAD_EN).
// Latency: frame_valid rises the cycle after the last beat is accepted.
// Backpressure: s_ready is low while a frame is held; released by frame_ack.
module cnn_image_loader
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cnn_image_loader_if.slave bus,
  output logic [CNT_W-1:0] pix_count,
  output logic             sync_err
);
  loader_state_e state, state_nxt;

  logic                  accept;
  logic                  sof_beat;
  logic                  store_beat;
  logic                  last;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] mem [FRAME_PIXELS];

  // Acceptance is decoded from state only, so s_ready never depends on s_valid.
  assign accept     = bus.s_valid && (state != FULL);
  assign sof_beat   = accept && bus.s_sof;
  assign store_beat = accept && (bus.s_sof || (state == LOAD));

  cnn_loader_addr_gen u_addr (
    .clk    (clk),
    .reset  (reset),
    .beat   (store_beat),
    .sof    (bus.s_sof),
    .wr_idx (wr_idx),
    .last   (last)
  );

  // State register; reset drops any partial or held frame at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the state-decoded handshake outputs.
  always_comb begin
    state_nxt       = state;
    bus.s_ready     = 1'b1;
    bus.frame_valid = 1'b0;
    case (state)
      IDLE: if (sof_beat) state_nxt = LOAD;
      LOAD: if (store_beat && last) state_nxt = FULL;
      FULL: begin
        bus.s_ready     = 1'b0;
        bus.frame_valid = 1'b1;
        if (bus.frame_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter: restarts on SOF, holds while the frame is held, clears on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                pix_count <= '0;
    else if ((state == FULL) && bus.frame_ack) pix_count <= '0;
    else if (sof_beat)                         pix_count <= CNT_W'(1);
    else if (store_beat)                       pix_count <= pix_count + 1'b1;
  end

  // Sticky framing error: stray non-SOF beat while idle, or SOF mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_err <= 1'b0;
    else if (accept && (state == IDLE) && !bus.s_sof) sync_err <= 1'b1;
    else if (sof_beat && (state == LOAD))             sync_err <= 1'b1;
  end

  // Frame store: stale pixels survive a resync and are overwritten as the new frame arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FRAME_PIXELS; i++) mem[i] <= '0;
    end else if (store_beat) begin
`ifdef CNN_LOADER_PAD_EN
      if (bus.s_sof) begin
        for (int i = 0; i < FRAME_PIXELS; i++) begin
          if (is_border(i)) mem[i] <= '0;
        end
      end
`endif
      mem[wr_idx] <= bus.s_pixel;
    end
  end

  for (genvar g = 0; g < FRAME_PIXELS; g++) begin : g_flat
    assign bus.frame_data[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end
endmodule

// File: tb/tb_cnn_image_loader.sv
// Directed scoreboard bench for cnn_image_loader (covers the CNN_LOADER_PAD_EN build when defined).
// Latency: expects frame_valid the cycle after the last accepted beat.
// Backpressure: drives beats only while the loader is expected to be ready, except in the hold step.
module tb_cnn_image_loader;
  import cnn_pkg::*;

`ifdef CNN_LOADER_PAD_EN
  localparam int NBEATS = IN_W * IN_W;
`else
  localparam int NBEATS = FRAME_PIXELS;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_image_loader_if bus ();
  logic [CNT_W-1:0] pix_count;
  logic             sync_err;

  cnn_image_loader dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .pix_count (pix_count),
    .sync_err  (sync_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [DATA_WIDTH-1:0] shadow [FRAME_PIXELS];
  int                    mk = 0;
  logic [FRAME_BITS-1:0] exp_q [$];
  logic [FRAME_BITS-1:0] last_exp;
  logic [FRAME_BITS-1:0] f1;

  function automatic int map_idx(input int k);
`ifdef CNN_LOADER_PAD_EN
    return (2 + k / 28) * 32 + 2 + k % 28;
`else
    return k;
`endif
  endfunction

  function automatic logic [15:0] pix1(input int k);
`ifdef CNN_LOADER_PAD_EN
    return 16'(k + 1);
`else
    return 16'(k);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_beat(input logic [15:0] pix, input logic sof);
    logic [FRAME_BITS-1:0] tmp;
    if (sof) begin
      mk = 0;
`ifdef CNN_LOADER_PAD_EN
      for (int i = 0; i < FRAME_PIXELS; i++) begin
        if ((i / 32) < 2 || (i / 32) > 29 || (i % 32) < 2 || (i % 32) > 29) shadow[i] = '0;
      end
`endif
    end
    shadow[map_idx(mk)] = pix;
    mk++;
    if (mk == NBEATS) begin
      for (int i = 0; i < FRAME_PIXELS; i++) tmp[i*DATA_WIDTH +: DATA_WIDTH] = shadow[i];
      exp_q.push_back(tmp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] pix, input logic sof);
    bus.s_pixel = pix;
    bus.s_sof   = sof;
    bus.s_valid = 1'b1;
    cycle();
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic beat(input logic [15:0] pix, input logic sof);
    model_beat(pix, sof);
    drive(pix, sof);
  endtask

  task automatic check_frame(input string tag);
    logic [FRAME_BITS-1:0] expv;
    int nbad;
    int first;
    logic [15:0] got_px;
    logic [15:0] exp_px;
    nbad   = 0;
    first  = -1;
    got_px = '0;
    exp_px = '0;
    checks++;
    if (exp_q.size() == 0) begin
      nbad = -1;
    end else begin
      expv = exp_q.pop_front();
      last_exp = expv;
      for (int i = 0; i < FRAME_PIXELS; i++) begin
        if (bus.frame_data[i*DATA_WIDTH +: DATA_WIDTH] !== expv[i*DATA_WIDTH +: DATA_WIDTH]) begin
          if (first < 0) begin
            first  = i;
            got_px = bus.frame_data[i*DATA_WIDTH +: DATA_WIDTH];
            exp_px = expv[i*DATA_WIDTH +: DATA_WIDTH];
          end
          nbad++;
        end
      end
    end
    assert (nbad === 0) else begin
      failures++;
      $error("FAIL %s bad_pixels=%0d first_idx=%0d observed=%0h expected=%0h", tag, nbad, first, got_px, exp_px);
    end
  endtask

  task automatic ack_frame();
    bus.frame_ack = 1'b1;
    cycle();
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.s_pixel   = '0;
    bus.s_valid   = 1'b0;
    bus.s_sof     = 1'b0;
    bus.frame_ack = 1'b0;
    for (int i = 0; i < FRAME_PIXELS; i++) shadow[i] = '0;
    cycle();
    cycle();

    // Reset state
    check("rst_frame_valid", 32'(bus.frame_valid), 0);
    check("rst_s_ready", 32'(bus.s_ready), 1);
    check("rst_pix_count", 32'(pix_count), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check("rst_frame_data", 32'(bus.frame_data != '0), 0);
    reset = 1'b0;
    cycle();

    // Gap-free frame
    for (int k = 0; k < NBEATS; k++) begin
      if (k == NBEATS - 1) begin
        check("t1_fv_before_last", 32'(bus.frame_valid), 0);
        check("t1_cnt_before_last", 32'(pix_count), NBEATS - 1);
      end
      beat(pix1(k), k == 0);
    end
    check("t1_frame_valid", 32'(bus.frame_valid), 1);
    check("t1_s_ready_full", 32'(bus.s_ready), 0);
    check("t1_pix_count", 32'(pix_count), NBEATS);
    check("t1_sync_err", 32'(sync_err), 0);
`ifdef CNN_LOADER_PAD_EN
    check("pad_px_2_2", 32'(bus.frame_data[(2*32+2)*16 +: 16]), 1);
    check("pad_px_29_29", 32'(bus.frame_data[(29*32+29)*16 +: 16]), 784);
    check("pad_px_0_0", 32'(bus.frame_data[0 +: 16]), 0);
`else
    check("t1_px_last", 32'(bus.frame_data[1023*16 +: 16]), 1023);
`endif
    check_frame("t1_frame");
    f1 = last_exp;

    // Hold with s_valid asserted throughout
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.s_pixel = 16'($urandom);
      cycle();
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    check("t2_hold_fv", 32'(bus.frame_valid), 1);
    check("t2_hold_cnt", 32'(pix_count), NBEATS);
    check("t2_hold_data", 32'(bus.frame_data !== last_exp), 0);
    ack_frame();
    check("t2_ack_fv", 32'(bus.frame_valid), 0);
    check("t2_ack_ready", 32'(bus.s_ready), 1);
    check("t2_ack_cnt", 32'(pix_count), 0);
    check("t2_data_kept", 32'(bus.frame_data !== last_exp), 0);

    // Stray beats while idle
    for (int i = 0; i < 3; i++) drive(16'($urandom), 1'b0);
    check("t3_cnt", 32'(pix_count), 0);
    check("t3_sync_err", 32'(sync_err), 1);
    check("t3_fv", 32'(bus.frame_valid), 0);
    for (int k = 0; k < NBEATS; k++) beat(16'(k * 3 + 7), k == 0);
    check("t3_fv_after", 32'(bus.frame_valid), 1);
    check_frame("t3_frame");
    ack_frame();

    // Resync mid-frame
    for (int k = 0; k < 100; k++) beat(16'(16'hA000 + k), k == 0);
    check("t4_partial_cnt", 32'(pix_count), 100);
    for (int k = 0; k < NBEATS; k++) beat(16'(k) ^ 16'h5A5A, k == 0);
    check("t4_fv", 32'(bus.frame_valid), 1);
    check("t4_sync_err", 32'(sync_err), 1);
    check_frame("t4_frame");
    ack_frame();

    // Random gaps with ack pulses outside FULL
    for (int i = 0; i < 3; i++) begin
      bus.frame_ack = 1'b1;
      cycle();
    end
    bus.frame_ack = 1'b0;
    check("t5_idle_ack_ready", 32'(bus.s_ready), 1);
    for (int k = 0; k < NBEATS; k++) begin
      while ($urandom_range(0, 99) < 30) begin
        bus.frame_ack = 1'($urandom_range(0, 1));
        cycle();
        bus.frame_ack = 1'b0;
      end
      if (k == NBEATS / 2) check("t5_mid_cnt", 32'(pix_count), NBEATS / 2);
      beat(pix1(k), k == 0);
    end
    begin
      int w;
      w = 0;
      while (!bus.frame_valid && w < 20) begin
        cycle();
        w++;
      end
    end
    check("t5_fv", 32'(bus.frame_valid), 1);
    check("t5_cnt", 32'(pix_count), NBEATS);
    check_frame("t5_frame");
    check("t5_same_as_t1", 32'(bus.frame_data !== f1), 0);
    ack_frame();

    // Asynchronous reset mid-load
    for (int k = 0; k < 10; k++) drive(16'(k), k == 0);
    check("t6_cnt_pre", 32'(pix_count), 10);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_cnt", 32'(pix_count), 0);
    check("t6_async_err", 32'(sync_err), 0);
    check("t6_async_data", 32'(bus.frame_data != '0), 0);
    cycle();
    reset = 1'b0;
    cycle();
    check("t6_ready", 32'(bus.s_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_image_loader.md
Name: cnn_image_loader

Overview:
Upstream front-end of the LeNet pipeline. Accepts a raster-order pixel stream over a valid/ready handshake and assembles one complete image into a 32x32x16-bit frame register. It presents that register as the flat image bus consumed by the convolution stage, with a frame_valid/frame_ack handshake in place of a free-running cycle count. It holds the frame stable until the consumer acknowledges it, then accepts the next frame.

Parameters:
DATA_WIDTH, 16, pixel width in bits (Q-format identical to the convolution input)
IMG_W, 32, stored frame width in pixels
IMG_H, 32, stored frame height in pixels
IN_W, 28, incoming frame width/height when CNN_LOADER_PAD_EN is defined (square input)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
s_pixel  input  DATA_WIDTH  incoming pixel
s_valid  input  1  s_pixel/s_sof valid
s_sof  input  1  marks first pixel of a frame
s_ready  output  1  loader can accept a beat
frame_data  output  IMG_W*IMG_H*DATA_WIDTH  flattened frame; pixel (r,c) at bits [(r*IMG_W+c)*DATA_WIDTH +: DATA_WIDTH]
frame_valid  output  1  frame_data complete and stable
frame_ack  input  1  consumer has finished with frame_data
pix_count  output  $clog2(IMG_W*IMG_H+1)  pixels stored in the current frame
sync_err  output  1  sticky framing-error flag

Behaviour:
- Beat transfers when s_valid && s_ready on a rising clk edge.
- States: IDLE (waiting for SOF), LOAD, FULL.
- Reset (asynchronous): state=IDLE, frame_data=0, frame_valid=0, pix_count=0, sync_err=0. s_ready=1 after reset.
- IDLE: s_ready=1.
  - Beat with s_sof=1: write pixel to index 0, pix_count=1, go to LOAD.
  - Beat with s_sof=0: discarded; sync_err<=1.
- LOAD: s_ready=1. Each beat writes index pix_count, then pix_count++.
  - Beat with s_sof=1 while pix_count>0: resync. Pixel written to index 0, pix_count=1, sync_err<=1. Stale data at higher indices is left in place and overwritten later.
  - Beat that writes the last index (IMG_W*IMG_H-1) moves to FULL. frame_valid=1 in the following cycle (1-cycle latency from last accepted beat).
- FULL: s_ready=0, frame_valid=1, frame_data frozen, pix_count holds at IMG_W*IMG_H.
  - frame_ack=1 sampled in FULL: next cycle state=IDLE, frame_valid=0, pix_count=0, s_ready=1. frame_data is not cleared.
- frame_ack outside FULL is ignored. s_sof on a beat that is not accepted has no effect.
- s_ready is a registered/state-decoded output with no combinational path from s_valid.
- sync_err clears only on reset.
- Reset mid-LOAD or mid-FULL discards the partial or held frame immediately. frame_valid drops asynchronously.

Optional Feature:
Macro CNN_LOADER_PAD_EN.
- Defined: input frames are IN_W x IN_W (784 beats). Pixel k of the input is stored at (r,c)=(PAD+k/IN_W, PAD+k%IN_W), with PAD=(IMG_W-IN_W)/2=2.
  - Border pixels are forced to 0 on the first beat of every frame (SOF accept).
  - Frame completes after IN_W*IN_W beats; pix_count counts input beats.
- Not defined: frame is IMG_W*IMG_H beats stored directly at index pix_count; no zeroing.

Decomposition:
- Shared package cnn_pkg: DATA_WIDTH, IMG_W, IMG_H, IN_W, PAD, FRAME_PIXELS, FRAME_BITS, and the loader state enum (IDLE/LOAD/FULL).
- One sub-module, cnn_loader_addr_gen: owns the row/column counters and produces the write index and last-beat flag (pad offset applied when CNN_LOADER_PAD_EN is defined).
- Top module holds the FSM, frame register and handshakes.

Test Plan:
- Reset, then SOF + 1024 beats with pixel=index, one beat per cycle -> frame_valid rises 1 cycle after beat 1023. Bits [16*i +: 16]==i for all i. s_ready=0 while FULL. sync_err=0.
- Frame held with frame_ack low for 50 cycles, s_valid asserted throughout -> no beats accepted, frame_data unchanged. Assert ack -> frame_valid=0 and s_ready=1 next cycle.
- 3 beats with s_sof=0 from IDLE -> beats discarded, pix_count=0, sync_err=1. Following SOF frame loads normally.
- SOF, 100 beats, then SOF again + 1024 beats -> frame indices 0..1023 hold the second frame's values, sync_err=1.
- Random s_valid gaps (about 30% idle) and frame_ack pulsed in IDLE/LOAD -> ack ignored. Frame content and completion identical to the gap-free case.
- CNN_LOADER_PAD_EN defined, 784 beats pixel=k+1 -> (2,2)=1, (29,29)=784, rows 0,1,30,31 and cols 0,1,30,31 all 0. frame_valid after beat 783.
